// File: rtl/calc_pkg.sv
// Shared types and codes for the calculator ALU front-end.
// Command/response codes, port state, issue tag layout, command check.
package calc_pkg;

    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_OK   = 2'b01;
    localparam logic [1:0] RSP_ERR  = 2'b10;
    localparam logic [1:0] RSP_BUSY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_QUEUED,
        ST_ISSUED
    } port_state_t;

    typedef struct packed {
        logic       seq;
        logic [1:0] idx;
    } tag_t;

    function automatic logic cmd_valid(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter for four requesters with grant hold.
// Ports: clk, rst_n, req mask, hold (offer stalled), fire (handshake), grant, grant_idx.
module calc_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       hold,
    input  logic       fire,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] ptr;
    logic       hold_q;
    logic [3:0] gnt_q;
    logic [3:0] rr_gnt;
    logic [1:0] idx;
    logic       found;

    // Search starts one past the last granted port.
    always_comb begin
        rr_gnt = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                rr_gnt[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // A stalled offer keeps its grant even if new ports queue up.
    assign grant = hold_q ? gnt_q : rr_gnt;

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (grant[k]) grant_idx = 2'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 2'd3;
            hold_q <= 1'b0;
            gnt_q  <= '0;
        end else begin
            hold_q <= hold;
            if (hold) gnt_q <= grant;
            if (fire) ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/calc_port_scheduler.sv
// Four-port two-cycle request front-end onto one tagged ALU issue interface.
// Ports: per-port cmd/data in, resp/data out; alu issue (valid/ready/cmd/ops/tag),
// alu response (valid/tag/rsp/data), sticky stray_rsp.
module calc_port_scheduler
    import calc_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [1:0]        out_resp1,
    output logic [1:0]        out_resp2,
    output logic [1:0]        out_resp3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [DATA_W-1:0] out_data4,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [2:0]        alu_tag,
    input  logic              alu_rsp_valid,
    input  logic [2:0]        alu_rsp_tag,
    input  logic [1:0]        alu_rsp,
    input  logic [DATA_W-1:0] alu_rsp_data,
    output logic              stray_rsp
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]        cmd_in [NUM_PORTS];
    logic [DATA_W-1:0] data_in[NUM_PORTS];
    logic [3:0]        cmd_v  [NUM_PORTS];
    logic [DATA_W-1:0] op1_v  [NUM_PORTS];
    logic [DATA_W-1:0] op2_v  [NUM_PORTS];
    logic [1:0]        resp_v [NUM_PORTS];
    logic [DATA_W-1:0] data_v [NUM_PORTS];
    logic [3:0]        seq_v;
    logic [3:0]        queued;
    logic [3:0]        match;
    logic [3:0]        grant;
    logic [1:0]        gidx;
    logic              fire;
    logic              hold;
    tag_t              rtag;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign rtag = tag_t'(alu_rsp_tag);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        port_state_t       st;
        logic [3:0]        cmd_q;
        logic [DATA_W-1:0] op1_q;
        logic [DATA_W-1:0] op2_q;
        logic              inv_q;
        logic              seq_q;
        logic [TW-1:0]     timer_q;
        logic [1:0]        pend_q;
        logic [1:0]        resp_q;
        logic [DATA_W-1:0] data_q;
        logic              busy;
        logic              bad_op2;
        logic              hit;
        logic              tmo;
        logic [1:0]        err_now;

        assign busy = (st == ST_QUEUED || st == ST_ISSUED) &&
                      cmd_in[i] != CMD_NONE;
        assign bad_op2 = (st == ST_OP2) && inv_q;
        assign hit = alu_rsp_valid && rtag.idx == 2'(i) &&
                     st == ST_ISSUED && rtag.seq == seq_q;
        assign tmo = st == ST_ISSUED && !hit &&
                     timer_q == TW'(TIMEOUT - 1);
        // OR-merge: BUSY (11) absorbs ERR (10).
        assign err_now = pend_q |
                         (busy ? RSP_BUSY : RSP_NONE) |
                         (bad_op2 ? RSP_ERR : RSP_NONE);

        assign queued[i] = (st == ST_QUEUED);
        assign match[i]  = hit;
        assign seq_v[i]  = seq_q;
        assign cmd_v[i]  = cmd_q;
        assign op1_v[i]  = op1_q;
        assign op2_v[i]  = op2_q;
        assign resp_v[i] = resp_q;
        assign data_v[i] = data_q;

        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                st      <= ST_IDLE;
                cmd_q   <= '0;
                op1_q   <= '0;
                op2_q   <= '0;
                inv_q   <= 1'b0;
                seq_q   <= 1'b0;
                timer_q <= '0;
                pend_q  <= RSP_NONE;
                resp_q  <= RSP_NONE;
                data_q  <= '0;
            end else begin
                unique case (st)
                    ST_IDLE: begin
                        if (cmd_in[i] != CMD_NONE) begin
                            st    <= ST_OP2;
                            cmd_q <= cmd_in[i];
                            op1_q <= data_in[i];
                            inv_q <= !cmd_valid(cmd_in[i]);
                        end
                    end
                    ST_OP2: begin
                        if (inv_q) begin
                            st <= ST_IDLE;
                        end else begin
                            op2_q <= data_in[i];
                            st    <= ST_QUEUED;
                        end
                    end
                    ST_QUEUED: begin
                        if (fire && grant[i]) begin
                            st      <= ST_ISSUED;
                            timer_q <= '0;
                            seq_q   <= ~seq_q;
                        end
                    end
                    ST_ISSUED: begin
                        if (hit || tmo) st <= ST_IDLE;
                        else timer_q <= timer_q + TW'(1);
                    end
                    default: st <= ST_IDLE;
                endcase

                // ALU result or timeout owns the slot; errors wait.
                if (hit) begin
                    resp_q <= alu_rsp;
                    data_q <= (alu_rsp == RSP_OK) ? alu_rsp_data : '0;
                    pend_q <= err_now;
                end else if (tmo) begin
                    resp_q <= RSP_BUSY;
                    data_q <= '0;
                    pend_q <= err_now;
                end else begin
                    resp_q <= err_now;
                    data_q <= '0;
                    pend_q <= RSP_NONE;
                end
            end
        end
    end

    assign alu_valid = |queued;
    assign fire      = alu_valid && alu_ready;
    assign hold      = alu_valid && !alu_ready;

    calc_rr_arbiter u_arb (
        .clk       (c_clk),
        .rst_n     (reset),
        .req       (queued),
        .hold      (hold),
        .fire      (fire),
        .grant     (grant),
        .grant_idx (gidx)
    );

    // Tag carries the seq value the port will hold after this issue.
    always_comb begin
        alu_cmd = '0;
        alu_op1 = '0;
        alu_op2 = '0;
        alu_tag = '0;
        if (alu_valid) begin
            alu_cmd = cmd_v[gidx];
            alu_op1 = op1_v[gidx];
            alu_op2 = op2_v[gidx];
            alu_tag = {~seq_v[gidx], gidx};
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) stray_rsp <= 1'b0;
        else if (alu_rsp_valid && match == '0) stray_rsp <= 1'b1;
    end

    assign out_resp1 = resp_v[0];
    assign out_resp2 = resp_v[1];
    assign out_resp3 = resp_v[2];
    assign out_resp4 = resp_v[3];
    assign out_data1 = data_v[0];
    assign out_data2 = data_v[1];
    assign out_data3 = data_v[2];
    assign out_data4 = data_v[3];

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Self-checking bench for calc_port_scheduler.
// Table-driven cycle vectors plus directed multi-cycle sequences.
module tb_calc_port_scheduler;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd [4];
    logic [31:0] req_data[4];
    logic [1:0]  resp    [4];
    logic [31:0] odata   [4];
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [2:0]  alu_tag;
    logic        alu_rsp_valid;
    logic [2:0]  alu_rsp_tag;
    logic [1:0]  alu_rsp;
    logic [31:0] alu_rsp_data;
    logic        stray_rsp;

    int nchk = 0;
    int nerr = 0;

    always #5 c_clk = ~c_clk;

    calc_port_scheduler dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req1_cmd_in   (req_cmd[0]),
        .req2_cmd_in   (req_cmd[1]),
        .req3_cmd_in   (req_cmd[2]),
        .req4_cmd_in   (req_cmd[3]),
        .req1_data_in  (req_data[0]),
        .req2_data_in  (req_data[1]),
        .req3_data_in  (req_data[2]),
        .req4_data_in  (req_data[3]),
        .out_resp1     (resp[0]),
        .out_resp2     (resp[1]),
        .out_resp3     (resp[2]),
        .out_resp4     (resp[3]),
        .out_data1     (odata[0]),
        .out_data2     (odata[1]),
        .out_data3     (odata[2]),
        .out_data4     (odata[3]),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_cmd       (alu_cmd),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_tag       (alu_tag),
        .alu_rsp_valid (alu_rsp_valid),
        .alu_rsp_tag   (alu_rsp_tag),
        .alu_rsp       (alu_rsp),
        .alu_rsp_data  (alu_rsp_data),
        .stray_rsp     (stray_rsp)
    );

    typedef struct packed {
        logic             do_rst;
        logic [3:0][3:0]  cmd;
        logic [3:0][31:0] data;
        logic             rdy;
        logic             rv;
        logic [2:0]       rtag;
        logic [1:0]       rsp;
        logic [31:0]      rdata;
        logic             ev;
        logic [2:0]       etag;
        logic [3:0]       ecmd;
        logic [31:0]      eop1;
        logic [31:0]      eop2;
        logic [3:0][1:0]  eresp;
        logic [3:0][31:0] edata;
        logic             estray;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        for (int p = 0; p < 4; p++) begin
            req_cmd[p]  = 4'd0;
            req_data[p] = 32'd0;
        end
        alu_ready     = 1'b0;
        alu_rsp_valid = 1'b0;
        alu_rsp_tag   = 3'd0;
        alu_rsp       = 2'd0;
        alu_rsp_data  = 32'd0;
    endtask

    task automatic step();
        @(posedge c_clk);
        @(negedge c_clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic build();
        vec_t v;
        // port1 add 1 + 0x1FFFFFF, response 3 cycles after issue
        v = '0; v.cmd[0] = 4'd1; v.data[0] = 32'd1; tbl.push_back(v);
        v = '0; v.data[0] = 32'h01FF_FFFF; v.ev = 1'b1;
        v.etag = 3'b100; v.ecmd = 4'd1; v.eop1 = 32'd1;
        v.eop2 = 32'h01FF_FFFF; tbl.push_back(v);
        v = '0; v.rdy = 1'b1; tbl.push_back(v);
        v = '0; tbl.push_back(v);
        v = '0; tbl.push_back(v);
        v = '0; v.rv = 1'b1; v.rtag = 3'b100; v.rsp = 2'b01;
        v.rdata = 32'h0200_0000; v.eresp[0] = 2'b01;
        v.edata[0] = 32'h0200_0000; tbl.push_back(v);
        v = '0; tbl.push_back(v);
        // all four ports at once, ready always high
        v = '0; v.do_rst = 1'b1; v.rdy = 1'b1;
        for (int p = 0; p < 4; p++) begin
            v.cmd[p]  = 4'd1;
            v.data[p] = 32'h10 * (p + 1);
        end
        tbl.push_back(v);
        for (int p = 0; p < 4; p++) begin
            v = '0; v.rdy = 1'b1;
            if (p == 0)
                for (int q = 0; q < 4; q++) v.data[q] = q + 1;
            v.ev = 1'b1; v.etag = {1'b1, 2'(p)}; v.ecmd = 4'd1;
            v.eop1 = 32'h10 * (p + 1); v.eop2 = p + 1;
            tbl.push_back(v);
        end
        v = '0; v.rdy = 1'b1; tbl.push_back(v);
        v = '0; v.rv = 1'b1; v.rtag = 3'b110; v.rsp = 2'b01;
        v.rdata = 32'h33; v.eresp[2] = 2'b01; v.edata[2] = 32'h33;
        tbl.push_back(v);
        v = '0; v.rv = 1'b1; v.rtag = 3'b100; v.rsp = 2'b01;
        v.rdata = 32'h11; v.eresp[0] = 2'b01; v.edata[0] = 32'h11;
        tbl.push_back(v);
        v = '0; v.rv = 1'b1; v.rtag = 3'b111; v.rsp = 2'b10;
        v.rdata = 32'h44; v.eresp[3] = 2'b10; tbl.push_back(v);
        v = '0; v.rv = 1'b1; v.rtag = 3'b101; v.rsp = 2'b01;
        v.rdata = 32'h22; v.eresp[1] = 2'b01; v.edata[1] = 32'h22;
        tbl.push_back(v);
        v = '0; tbl.push_back(v);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge c_clk);
        chk("rst_valid", 32'(alu_valid), 32'd0);
        chk("rst_tag", 32'(alu_tag), 32'd0);
        chk("rst_stray", 32'(stray_rsp), 32'd0);
        for (int p = 0; p < 4; p++)
            chk($sformatf("rst_resp%0d", p + 1), 32'(resp[p]), 32'd0);
        step();
        reset = 1'b1;

        build();
        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].do_rst) do_reset();
            for (int p = 0; p < 4; p++) begin
                req_cmd[p]  = tbl[r].cmd[p];
                req_data[p] = tbl[r].data[p];
            end
            alu_ready     = tbl[r].rdy;
            alu_rsp_valid = tbl[r].rv;
            alu_rsp_tag   = tbl[r].rtag;
            alu_rsp       = tbl[r].rsp;
            alu_rsp_data  = tbl[r].rdata;
            step();
            chk($sformatf("r%0d valid", r), 32'(alu_valid), 32'(tbl[r].ev));
            if (tbl[r].ev) begin
                chk($sformatf("r%0d tag", r), 32'(alu_tag), 32'(tbl[r].etag));
                chk($sformatf("r%0d cmd", r), 32'(alu_cmd), 32'(tbl[r].ecmd));
                chk($sformatf("r%0d op1", r), alu_op1, tbl[r].eop1);
                chk($sformatf("r%0d op2", r), alu_op2, tbl[r].eop2);
            end
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("r%0d resp%0d", r, p + 1),
                    32'(resp[p]), 32'(tbl[r].eresp[p]));
                chk($sformatf("r%0d data%0d", r, p + 1),
                    odata[p], tbl[r].edata[p]);
            end
            chk($sformatf("r%0d stray", r), 32'(stray_rsp), 32'(tbl[r].estray));
        end
        idle();

        // invalid command on port2
        do_reset();
        req_cmd[1] = 4'd3; req_data[1] = 32'd5;
        step();
        chk("inv_resp2_a", 32'(resp[1]), 32'd0);
        idle(); req_data[1] = 32'd7;
        step();
        chk("inv_resp2", 32'(resp[1]), 32'b10);
        chk("inv_valid", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("inv_resp2_clr", 32'(resp[1]), 32'd0);
        chk("inv_valid2", 32'(alu_valid), 32'd0);

        // busy on port3 while issued, and busy deferred behind result
        do_reset();
        req_cmd[2] = 4'd1; req_data[2] = 32'd10;
        step();
        idle(); req_data[2] = 32'd20;
        step();
        chk("bsy_tag", 32'(alu_tag), 32'b110);
        idle(); alu_ready = 1'b1;
        step();
        chk("bsy_issued", 32'(alu_valid), 32'd0);
        idle(); req_cmd[2] = 4'd1; req_data[2] = 32'd99;
        step();
        chk("bsy_resp3", 32'(resp[2]), 32'b11);
        chk("bsy_data3", odata[2], 32'd0);
        chk("bsy_valid", 32'(alu_valid), 32'd0);
        idle();
        step();
        chk("bsy_resp3_clr", 32'(resp[2]), 32'd0);
        alu_rsp_valid = 1'b1; alu_rsp_tag = 3'b110;
        alu_rsp = 2'b01; alu_rsp_data = 32'd30;
        req_cmd[2] = 4'd1;
        step();
        chk("bsy_ok_resp3", 32'(resp[2]), 32'b01);
        chk("bsy_ok_data3", odata[2], 32'd30);
        idle();
        step();
        chk("bsy_defer_resp3", 32'(resp[2]), 32'b11);
        chk("bsy_defer_data3", odata[2], 32'd0);
        step();
        chk("bsy_end_resp3", 32'(resp[2]), 32'd0);
        chk("bsy_end_valid", 32'(alu_valid), 32'd0);
        chk("bsy_stray", 32'(stray_rsp), 32'd0);

        // timeout on port4 and late stray response
        do_reset();
        req_cmd[3] = 4'd1; req_data[3] = 32'd1;
        step();
        idle(); req_data[3] = 32'd2;
        step();
        chk("tmo_tag", 32'(alu_tag), 32'b111);
        idle(); alu_ready = 1'b1;
        step();
        idle();
        for (int k = 1; k <= 63; k++) step();
        chk("tmo_early", 32'(resp[3]), 32'd0);
        step();
        chk("tmo_resp4", 32'(resp[3]), 32'b11);
        chk("tmo_stray0", 32'(stray_rsp), 32'd0);
        step();
        chk("tmo_resp4_clr", 32'(resp[3]), 32'd0);
        alu_rsp_valid = 1'b1; alu_rsp_tag = 3'b111;
        alu_rsp = 2'b01; alu_rsp_data = 32'd3;
        step();
        chk("tmo_stray1", 32'(stray_rsp), 32'd1);
        chk("tmo_late_resp4", 32'(resp[3]), 32'd0);
        idle();
        step();
        chk("tmo_stray_sticky", 32'(stray_rsp), 32'd1);

        // held grant under stall, then async reset
        do_reset();
        req_cmd[1] = 4'd1; req_data[1] = 32'd3;
        step();
        idle(); req_data[1] = 32'd3;
        req_cmd[0] = 4'd1; req_data[0] = 32'd2;
        step();
        chk("hold_tag_a", 32'(alu_tag), 32'b101);
        idle(); req_data[0] = 32'd2;
        step();
        chk("hold_tag_b", 32'(alu_tag), 32'b101);
        idle();
        step();
        chk("hold_tag_c", 32'(alu_tag), 32'b101);
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(alu_valid), 32'd0);
        chk("arst_tag", 32'(alu_tag), 32'd0);
        chk("arst_cmd", 32'(alu_cmd), 32'd0);
        chk("arst_op1", alu_op1, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("arst_idle", 32'(alu_valid), 32'd0);
        req_cmd[0] = 4'd1; req_data[0] = 32'd2;
        step();
        idle(); req_data[0] = 32'd2;
        step();
        chk("post_tag", 32'(alu_tag), 32'b100);
        chk("post_op1", alu_op1, 32'd2);
        chk("post_op2", alu_op2, 32'd2);
        idle(); alu_ready = 1'b1;
        step();
        idle();
        alu_rsp_valid = 1'b1; alu_rsp_tag = 3'b100;
        alu_rsp = 2'b01; alu_rsp_data = 32'd4;
        step();
        chk("post_resp1", 32'(resp[0]), 32'b01);
        chk("post_data1", odata[0], 32'd4);
        chk("post_stray", 32'(stray_rsp), 32'd0);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/calc_port_scheduler.md
Name: calc_port_scheduler

Overview:
- Front-end for the shared calculator ALU.
- Accepts the two-cycle request protocol on four requester ports. Each request is a command plus operand 1 in one cycle, then operand 2 in the next.
- Arbitrates round-robin onto a single tagged ALU issue interface.
- Routes each ALU response back to the originating port. Guards each port with a busy check, an invalid-command check and a response timeout.

Parameters:
- NUM_PORTS, 4, requester count (tag port field is 2 bits; only 4 supported)
- DATA_W, 32, operand/result width
- TIMEOUT, 64, cycles from issue handshake to forced timeout response

Ports:
- c_clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- reqN_cmd_in  in  4  per port N=1..4; 0=none, 1=add, 2=sub, 5=shl, 6=shr
- reqN_data_in  in  DATA_W  operand 1 in cmd cycle, operand 2 in following cycle
- out_respN  out  2  per port; 00 none, 01 ok, 10 overflow/underflow/invalid, 11 busy/timeout
- out_dataN  out  DATA_W  result when out_respN=01, else 0
- alu_valid  out  1  issue offer
- alu_ready  in  1  ALU accepts offer this cycle
- alu_cmd  out  4  issued command
- alu_op1, alu_op2  out  DATA_W  issued operands
- alu_tag  out  3  {seq bit, port index[1:0]}
- alu_rsp_valid  in  1  ALU response strobe
- alu_rsp_tag  in  3  tag of response
- alu_rsp  in  2  01 ok / 10 arithmetic error
- alu_rsp_data  in  DATA_W  result
- stray_rsp  out  1  sticky; set on any discarded ALU response; cleared only by reset

Behaviour:
- Reset (reset=0, immediate):
  - All ports go to IDLE. RR pointer = port 4, so port 1 has first priority.
  - seq bits = 0. Pending errors are cleared and timers = 0.
  - All out_resp/out_data = 0, alu_valid = 0, alu_cmd/op/tag = 0, stray_rsp = 0.
  - Requests in flight are lost. ALU responses arriving after reset are stray.
- Per-port FSM:
  - IDLE, cmd!=0, valid cmd: capture cmd and op1, go to OP2.
  - IDLE, cmd!=0, invalid cmd: go to OP2 with inv flag set.
  - IDLE, cmd=0: stay in IDLE.
  - OP2 (data sampled as op2, cmd field ignored), inv set: go to IDLE and set pending error 10.
  - OP2, inv clear: capture op2 and go to QUEUED.
  - QUEUED: go to ISSUED on the cycle this port wins and alu_ready=1. Load timer=0 and toggle seq.
  - ISSUED: go to IDLE on a matching response or a timeout.
  - QUEUED or ISSUED with cmd!=0: cmd and data ignored, state unchanged, pending error 11 set. Busy is judged on the state before the edge.
- Arbitration:
  - alu_* is combinational from registered state.
  - alu_valid=1 whenever any port is QUEUED, beginning the cycle after the op2 edge.
  - Selection is round-robin starting after the last granted port.
  - While alu_valid=1 and alu_ready=0, the selection is held stable with no switching.
  - The RR pointer updates only on a handshake.
- Response match: alu_rsp_valid and port[tag] is ISSUED and seq matches. Otherwise the response is discarded and stray_rsp is set.
- Timeout: the timer counts in ISSUED. When timer reaches TIMEOUT-1 with no match, return 11 and go to IDLE. A later response for that tag is stray.
- Output timing:
  - Registered. out_respN/out_dataN are valid for exactly one cycle after the deciding edge, then return to 00/0.
  - Priority per port per cycle: ALU match or timeout, then pending error.
  - A match and a timeout on the same edge: the match wins.
  - Multiple pending errors of the same port merge into one response. Code 11 wins over 10.
  - A deferred pending error is emitted on the first free response cycle.
- ALU latency is not assumed. At most 4 requests are outstanding, one per port.
- Minimum round trip: ALU response sampled at edge E means out_respN is visible in the cycle after E.

Decomposition:
- Shared package calc_pkg:
  - command codes CMD_NONE/ADD/SUB/SHL/SHR
  - response codes RSP_NONE/OK/ERR/BUSY
  - port-state enum
  - tag typedef {seq, idx}
  - a valid-command function
- One natural sub-module: calc_rr_arbiter. It takes a 4-bit request mask and a hold input, and gives a one-hot grant and a pointer update on handshake.
- Per-port logic is a generate loop in the top module, not a sub-module.

Test Plan:
- Port1 add 1 + 0x1FFFFFF, ALU returns 01/0x2000000 after 3 cycles with tag {1,0} -> out_resp1=01, out_data1=0x2000000 for exactly one cycle. Other ports stay at 00.
- All four ports issue add on the same cycle, with alu_ready=1 always -> grants in order 1,2,3,4 on consecutive cycles. Tags are {1,0},{1,1},{1,2},{1,3}. Responses returned out of order are routed correctly.
- Port2 sends cmd=3 and then data -> no alu_valid. out_resp2=10 in the cycle after the op2 edge.
- Port3 sends cmd=1 while its request is ISSUED -> request unaffected. out_resp3=11 once. The original result arrives later with 01.
- With ALU silent and TIMEOUT=64 -> out_resp4=11 at issue+64. A later response with the old tag is dropped and stray_rsp=1.
- reset pulled low while ports 1 and 2 are QUEUED and alu_ready=0 -> all outputs 0 immediately. After release, port1 add 2+2 gives 01 with result 4.
